alu_flag_unit: RTL
==================

ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, sole clock; all state updates on rising edge.
REQ-003 Port `reset`: input, 1 bit, synchronous, active-high reset.
REQ-004 Port `A`: input, 8 bits, operand A, driven from register-file output O1.
REQ-005 Port `B`: input, 8 bits, operand B, driven from register-file output O2.
REQ-006 Port `FunSel`: input, 4 bits, operation select (REQ-011).
REQ-007 Port `En`: input, 1 bit, operation strobe; operands and FunSel sampled on a clk edge with En=1.
REQ-008 Port `OutALU`: output, 8 bits, registered result.
REQ-009 Port `Flags`: output, 4 bits, registered {Z,C,N,O}; Z is bit 3, O is bit 0.
REQ-010 Port `Valid`: output, 1 bit, high for exactly one cycle after each accepted operation.

Function
REQ-011 FunSel decode SHALL be:
- 0000 A; 0001 B; 0010 ~A; 0011 ~B
- 0100 A+B; 0101 A+B+C; 0110 A-B (computed as A+~B+1)
- 0111 A&B; 1000 A|B; 1001 A^B
- 1010 LSL A; 1011 LSR A; 1100 ASL A; 1101 ASR A
- 1110 CSL A = {A[6:0],C}; 1111 CSR A = {C,A[7:1]}
REQ-012 On a clk edge with En=1 and reset=0, OutALU SHALL load the 8-bit result of the selected operation; latency is 1 cycle.
REQ-013 Arithmetic SHALL be 9-bit internally; OutALU = bits [7:0], discarding the carry.
REQ-014 Z SHALL update on every accepted operation: Z = 1 when the result is 8'h00.
REQ-015 N SHALL update on every accepted operation: N = result[7].
REQ-016 C SHALL update only for FunSel 0100-0110 and 1010-1111; other operations hold C.
- Add/ADC: C = bit 8 of the sum.
- SUB: C = bit 8 of A+~B+1 (1 = no borrow).
- LSL/ASL/CSL: C = A[7].
- LSR/ASR/CSR: C = A[0].
REQ-017 O SHALL update only for FunSel 0100, 0101, 0110 and 1100; other operations hold O.
- Add/ADC/SUB: O = signed overflow of the effective operands.
- ASL: O = A[7]^A[6].
REQ-018 ADC, CSL and CSR SHALL use the C value held in Flags before the edge, never the value being computed.
REQ-019 LSL and ASL SHALL both shift in 0 at bit 0.
REQ-020 LSR SHALL shift in 0 at bit 7.
REQ-021 ASR SHALL replicate A[7] into bit 7.
REQ-022 With En=0, OutALU and Flags SHALL hold their values and Valid SHALL be 0 on the next cycle.
REQ-023 Valid SHALL equal the registered value of En: back-to-back En=1 gives Valid high every cycle, one result per cycle, with no stall.
REQ-024 Operands and FunSel SHALL be ignored on any cycle where En=0.

Reset
REQ-025 On a clk edge with reset=1, OutALU SHALL be 8'h00, Flags 4'b0000 and Valid 0.
REQ-026 Reset SHALL take priority over En on the same edge; an operation presented alongside reset is discarded and produces no Valid.
REQ-027 Reset asserted between an accepted operation and its Valid cycle SHALL suppress that Valid.
REQ-028 Outputs are undefined before the first reset edge; the bench SHALL apply reset before any check.

Verification
REQ-029 Reset held 2 cycles -> OutALU=00, Flags=0000, Valid=0.
REQ-030 A=7F, B=01, FunSel=0100, En=1 -> next cycle OutALU=80, Z0 C0 N1 O1, Valid=1.
REQ-031 A=05, B=05, FunSel=0110 -> OutALU=00, Z1 C1 N0 O0. Then A=FF, B=00, FunSel=0101 -> OutALU=00, Z1 C1 N0 O0 (carry-in used).
REQ-032 With C=1: A=02, FunSel=1111 -> OutALU=81, C0 N1 Z0, O held. Then A=81, FunSel=1110 -> OutALU=02, C1, N0.
REQ-033 Prior Flags=1100: A=F0, B=0F, FunSel=0111 -> OutALU=00, Z1 N0, C and O held (C1 O0). Then En=0 for 3 cycles -> OutALU and Flags unchanged, Valid=0.
REQ-034 En=1 with A=7F, B=01, FunSel=0100 and reset=1 on the same edge -> OutALU=00, Flags=0000, Valid=0 the following cycle.

Source files
------------

// File: rtl/alu_flag_unit_if.sv
// Operand/result bundle between the register file and the ALU flag unit.
// The master drives operands and strobe; the slave returns the registered result, flags and valid.
interface alu_flag_unit_if;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] FunSel;
   logic       En;
   logic [7:0] OutALU;
   logic [3:0] Flags;
   logic       Valid;

   modport master (output A, B, FunSel, En, input OutALU, Flags, Valid);
   modport slave  (input A, B, FunSel, En, output OutALU, Flags, Valid);
endinterface

// File: rtl/alu_flag_unit.sv
// 8-bit ALU with {Z,C,N,O} flag register; one registered result per En strobe, 1-cycle latency.
// Never stalls: Valid is En delayed by one cycle, cleared by synchronous reset.
module alu_flag_unit (
   input  logic           clk,
   input  logic           reset,
   alu_flag_unit_if.slave bus
);
   logic [7:0] r_out;
   logic [3:0] r_flags;
   logic       r_valid;

   logic [7:0] w_a;
   logic [7:0] w_b;
   logic       w_cin;
   logic [8:0] w_sum;
   logic [7:0] w_res;
   logic       w_c;
   logic       w_o;

   assign w_a   = bus.A;
   assign w_b   = bus.B;
   assign w_cin = r_flags[2];

   // C and O default to their held values; only the ops that own them overwrite.
   always_comb begin
      w_sum = 9'h000;
      w_res = 8'h00;
      w_c   = r_flags[2];
      w_o   = r_flags[0];
      case (bus.FunSel)
         4'b0000: w_res = w_a;
         4'b0001: w_res = w_b;
         4'b0010: w_res = ~w_a;
         4'b0011: w_res = ~w_b;
         4'b0100: begin
            w_sum = {1'b0, w_a} + {1'b0, w_b};
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            w_o   = (w_a[7] == w_b[7]) && (w_sum[7] != w_a[7]);
         end
         4'b0101: begin
            w_sum = {1'b0, w_a} + {1'b0, w_b} + {8'h00, w_cin};
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            w_o   = (w_a[7] == w_b[7]) && (w_sum[7] != w_a[7]);
         end
         4'b0110: begin
            w_sum = {1'b0, w_a} + {1'b0, ~w_b} + 9'd1;
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            w_o   = (w_a[7] != w_b[7]) && (w_sum[7] != w_a[7]);
         end
         4'b0111: w_res = w_a & w_b;
         4'b1000: w_res = w_a | w_b;
         4'b1001: w_res = w_a ^ w_b;
         4'b1010: begin
            w_res = {w_a[6:0], 1'b0};
            w_c   = w_a[7];
         end
         4'b1011: begin
            w_res = {1'b0, w_a[7:1]};
            w_c   = w_a[0];
         end
         4'b1100: begin
            w_res = {w_a[6:0], 1'b0};
            w_c   = w_a[7];
            w_o   = w_a[7] ^ w_a[6];
         end
         4'b1101: begin
            w_res = {w_a[7], w_a[7:1]};
            w_c   = w_a[0];
         end
         4'b1110: begin
            w_res = {w_a[6:0], w_cin};
            w_c   = w_a[7];
         end
         default: begin
            w_res = {w_cin, w_a[7:1]};
            w_c   = w_a[0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out   <= 8'h00;
         r_flags <= 4'b0000;
         r_valid <= 1'b0;
      end else begin
         r_valid <= bus.En;
         if (bus.En) begin
            r_out   <= w_res;
            r_flags <= {(w_res == 8'h00), w_c, w_res[7], w_o};
         end
      end
   end

   assign bus.OutALU = r_out;
   assign bus.Flags  = r_flags;
   assign bus.Valid  = r_valid;
endmodule
